// File: rtl/i2s_tx.sv
// I2S transmitter: serialises stereo samples to a DAC as SCLK/LRCLK/SDATA derived from clk_in.
// Raises sample_req_out during the cycle a frame loads, so a same-cycle data_valid_in joins that frame.
module i2s_tx #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32,
  parameter int SCLK_DIV  = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             tx_enable,
  input  logic [WIDTH-1:0] data_in_l,
  input  logic [WIDTH-1:0] data_in_r,
  input  logic             data_valid_in,
  output logic             sample_req_out,
  output logic             sclk_out,
  output logic             lrclk_out,
  output logic             sdata_out,
  output logic             underrun_out,
  output logic             overrun_out
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DW-1:0]        r_div_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_sclk, r_lrclk, r_sdata, r_sample_req;
  logic                 r_underrun, r_overrun, r_pending;
  logic [WIDTH-1:0]     r_hold_l, r_hold_r, r_shift_l, r_shift_r;

  logic                 w_div_end, w_fall, w_load, w_req_nxt, w_right, w_sd;
  logic [BW-1:0]        w_bit_nxt, w_pos;
  logic [WIDTH-1:0]     w_word;
  logic [SLOT_BITS-1:0] w_slot, w_slot_shifted;

  always_comb begin
    w_div_end = (r_div_cnt == DW'(SCLK_DIV - 1));
    w_fall    = w_div_end && r_sclk;
    w_load    = w_fall && (r_bit_cnt == BW'(FRAME - 1));
    // Registered request lands exactly on the cycle whose closing edge performs the load.
    w_req_nxt = r_sclk && (r_div_cnt == DW'(SCLK_DIV - 2)) && (r_bit_cnt == BW'(FRAME - 1));
    w_bit_nxt = (r_bit_cnt == BW'(FRAME - 1)) ? '0 : r_bit_cnt + BW'(1);
    w_right   = (w_bit_nxt >= BW'(SLOT_BITS));
    w_pos     = w_right ? (w_bit_nxt - BW'(SLOT_BITS)) : w_bit_nxt;
    w_word    = w_right ? r_shift_r : r_shift_l;
    // Word sits at slot positions 1..WIDTH; position 0 and the tail stay zero.
    w_slot         = SLOT_BITS'(w_word) << (SLOT_BITS - 1 - WIDTH);
    w_slot_shifted = w_slot << w_pos;
    w_sd           = w_slot_shifted[SLOT_BITS-1];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_div_cnt    <= '0;
      r_bit_cnt    <= BW'(FRAME - 1);
      r_sclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_sdata      <= 1'b0;
      r_sample_req <= 1'b0;
      r_pending    <= 1'b0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_shift_l    <= '0;
      r_shift_r    <= '0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (!tx_enable) begin
      r_div_cnt    <= '0;
      r_bit_cnt    <= BW'(FRAME - 1);
      r_sclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_sdata      <= 1'b0;
      r_sample_req <= 1'b0;
      r_pending    <= 1'b0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_shift_l    <= '0;
      r_shift_r    <= '0;
    end else begin
      r_div_cnt    <= w_div_end ? '0 : r_div_cnt + DW'(1);
      r_sample_req <= w_req_nxt;
      if (w_div_end) r_sclk <= ~r_sclk;
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_right;
        r_sdata   <= w_sd;
      end
      if (w_load) begin
        r_pending <= 1'b0;
        if (data_valid_in) begin
          // Bypass; hold also takes the word so a later underrun resends it.
          r_shift_l <= data_in_l;
          r_shift_r <= data_in_r;
          r_hold_l  <= data_in_l;
          r_hold_r  <= data_in_r;
        end else begin
          r_shift_l <= r_hold_l;
          r_shift_r <= r_hold_r;
          if (!r_pending) r_underrun <= 1'b1;
        end
      end else if (data_valid_in) begin
        r_hold_l  <= data_in_l;
        r_hold_r  <= data_in_r;
        r_pending <= 1'b1;
        if (r_pending) r_overrun <= 1'b1;
      end
    end
  end

  assign sample_req_out = r_sample_req;
  assign sclk_out       = r_sclk;
  assign lrclk_out      = r_lrclk;
  assign sdata_out      = r_sdata;
  assign underrun_out   = r_underrun;
  assign overrun_out    = r_overrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: captures whole frames on SCLK rises and compares them with
// hand-written sample words, framing timing and the sticky underrun/overrun flags.
module tb_i2s_tx;

  logic        clk_in = 1'b0;
  logic        rst_in, tx_enable, data_valid_in;
  logic [15:0] data_in_l, data_in_r;
  logic        sample_req_out, sclk_out, lrclk_out, sdata_out, underrun_out, overrun_out;

  i2s_tx #(.WIDTH(16), .SLOT_BITS(32), .SCLK_DIV(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tx_enable(tx_enable),
    .data_in_l(data_in_l), .data_in_r(data_in_r), .data_valid_in(data_valid_in),
    .sample_req_out(sample_req_out), .sclk_out(sclk_out), .lrclk_out(lrclk_out),
    .sdata_out(sdata_out), .underrun_out(underrun_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  logic fr_sd [64];
  logic fr_lr [64];
  int   rise_t0, rise_t1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge inside the request cycle; t is the edge count at that point.
  task automatic wait_req(output int t);
    int k;
    k = 0;
    while (sample_req_out !== 1'b1 && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 3000) check("req_timeout", 32'(sample_req_out), 32'd1);
    t = cyc;
  endtask

  task automatic pulse_valid(input logic [15:0] l, input logic [15:0] r);
    data_in_l     = l;
    data_in_r     = r;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
  endtask

  task automatic capture();
    int   k, n;
    logic prev;
    k    = 0;
    n    = 0;
    prev = sclk_out;
    while (k < 64 && n < 2500) begin
      @(negedge clk_in);
      n++;
      if (sclk_out && !prev) begin
        fr_sd[k] = sdata_out;
        fr_lr[k] = lrclk_out;
        if (k == 0) rise_t0 = cyc;
        if (k == 1) rise_t1 = cyc;
        k++;
      end
      prev = sclk_out;
    end
    if (k < 64) check("cap_timeout", 32'(k), 32'd64);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
    logic [15:0] gl, gr;
    int          pad, lrbad, p;
    gl = '0; gr = '0; pad = 0; lrbad = 0;
    for (int i = 1; i <= 16; i++) begin
      gl = {gl[14:0], fr_sd[i]};
      gr = {gr[14:0], fr_sd[32+i]};
    end
    for (int k = 0; k < 64; k++) begin
      p = k % 32;
      if ((p == 0 || p > 16) && fr_sd[k] !== 1'b0) pad++;
      if (fr_lr[k] !== 1'(k >= 32)) lrbad++;
    end
    check({tag, "_l"}, 32'(gl), 32'(el));
    check({tag, "_r"}, 32'(gr), 32'(er));
    check({tag, "_pad"}, 32'(pad), 32'd0);
    check({tag, "_lr"}, 32'(lrbad), 32'd0);
  endtask

  initial begin
    int t, t_en, last_req, act;
    logic [15:0] rl, rr;
    rst_in = 1'b1; tx_enable = 1'b0; data_valid_in = 1'b0;
    data_in_l = '0; data_in_r = '0;
    repeat (3) @(negedge clk_in);
    check("rst_out", 32'({sclk_out, lrclk_out, sdata_out, sample_req_out, underrun_out, overrun_out}), 32'd0);
    rst_in = 1'b0;

    act = 0;
    repeat (1000) begin
      @(negedge clk_in);
      if (sclk_out | lrclk_out | sdata_out | sample_req_out) act++;
    end
    check("idle_activity", 32'(act), 32'd0);

    tx_enable = 1'b1;
    t_en = cyc;
    repeat (5) @(negedge clk_in);
    pulse_valid(16'hA5C3, 16'h8001);
    wait_req(t);
    // The load happens on the edge that closes the request cycle.
    check("first_load", 32'(t - t_en + 1), 32'd32);
    last_req = t;
    @(negedge clk_in);
    check("req_width", 32'(sample_req_out), 32'd0);
    capture();
    check_frame("f0", 16'hA5C3, 16'h8001);
    check("sclk_period", 32'(rise_t1 - rise_t0), 32'd32);
    check("f0_under", 32'(underrun_out), 32'd0);

    for (int i = 1; i <= 3; i++) begin
      wait_req(t);
      check($sformatf("req_gap%0d", i), 32'(t - last_req), 32'd2048);
      last_req = t;
      rl = 16'h1000 + 16'(i);
      rr = 16'h2000 + 16'(i);
      pulse_valid(rl, rr);
      capture();
      check_frame($sformatf("ramp%0d", i), rl, rr);
    end
    check("ramp_under", 32'(underrun_out), 32'd0);
    check("ramp_over", 32'(overrun_out), 32'd0);

    wait_req(t);
    @(negedge clk_in);
    check("under_set", 32'(underrun_out), 32'd1);
    repeat (2) @(negedge clk_in);
    pulse_valid(16'h1111, 16'h1111);
    check("over_clear", 32'(overrun_out), 32'd0);
    repeat (3) @(negedge clk_in);
    pulse_valid(16'h2222, 16'h2222);
    check("over_set", 32'(overrun_out), 32'd1);
    capture();
    check_frame("resend", 16'h1003, 16'h2003);

    wait_req(t);
    capture();
    check_frame("overwr", 16'h2222, 16'h2222);
    check("under_sticky", 32'(underrun_out), 32'd1);
    check("over_sticky", 32'(overrun_out), 32'd1);

    wait_req(t);
    repeat (1536) @(negedge clk_in);
    check("pre_rst_lr", 32'(lrclk_out), 32'd1);
    #2 rst_in = 1'b1;
    #1 check("rst_async", 32'({sclk_out, lrclk_out, sdata_out, sample_req_out, underrun_out, overrun_out}), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    t_en = cyc;
    repeat (4) @(negedge clk_in);
    pulse_valid(16'h7E81, 16'h0180);
    wait_req(t);
    check("rst_first_load", 32'(t - t_en + 1), 32'd32);
    capture();
    check_frame("post_rst", 16'h7E81, 16'h0180);
    check("post_rst_flags", 32'({underrun_out, overrun_out}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
